// File: rtl/register_file.sv
// register_file: architectural integer register file for the pipelined core.
// One write port from write-back, two combinational read ports for decode,
// and a per-register pending (busy) scoreboard used by the hazard logic to
// stall on in-flight loads. Register 0 is hardwired to zero and never busy.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  busy_set,
  input  logic [ADDR_WIDTH-1:0] busy_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  // Storage exists only for registers 1..NREG-1; index 0 is synthesised as a constant.
  logic [DATA_WIDTH-1:0] regs [1:NREG-1];
  logic [NREG-1:1]       busy;

  // Decoded one-hot write and busy-set strobes; address 0 never decodes.
  logic [NREG-1:1] wr_hit;
  logic [NREG-1:1] set_hit;

  // Address decode for the write-back demux and the scoreboard set port
  always_comb begin
    wr_hit  = '0;
    set_hit = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      wr_hit[r]  = we && (rd_addr == ADDR_WIDTH'(r));
      set_hit[r] = busy_set && (busy_addr == ADDR_WIDTH'(r));
    end
  end

  // Register array update: synchronous clear, otherwise write-back demux
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 1; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= rd_data;
        end
      end
    end
  end

  // Scoreboard update: a load issue (set) beats a same-cycle write-back (clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (set_hit[r]) begin
          busy[r] <= 1'b1;
        end else if (wr_hit[r]) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // Read port 1: zero for x0, write-through bypass, else array lookup
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (rs1_addr != '0) begin
      if (we && (rd_addr == rs1_addr)) begin
        rs1_data = rd_data;
        rs1_busy = 1'b0;
      end else begin
        // Array read written as a compare-select so that index 0 is never addressed.
        for (int unsigned r = 1; r < NREG; r++) begin
          if (rs1_addr == ADDR_WIDTH'(r)) begin
            rs1_data = regs[r];
            rs1_busy = busy[r];
          end
        end
      end
    end
  end

  // Read port 2: identical structure to port 1
  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rs2_addr != '0) begin
      if (we && (rd_addr == rs2_addr)) begin
        rs2_data = rd_data;
        rs2_busy = 1'b0;
      end else begin
        for (int unsigned r = 1; r < NREG; r++) begin
          if (rs2_addr == ADDR_WIDTH'(r)) begin
            rs2_data = regs[r];
            rs2_busy = busy[r];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed test-plan scenarios followed by random traffic,
// checked against an array-based reference model through a scoreboard queue.
module tb_register_file;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rs1_addr, rs2_addr, rd_addr, busy_addr;
  logic [DW-1:0] rs1_data, rs2_data, rd_data;
  logic          we, busy_set, rs1_busy, rs2_busy;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          b1;
    logic          b2;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: plain architectural state.
  logic [DW-1:0] m_regs [NREG];
  logic          m_busy [NREG];

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input logic w,
                                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (w && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic m_bsy(input logic [AW-1:0] a, input logic w, input logic [AW-1:0] wa);
    if (a == 0) return 1'b0;
    if (w && wa == a) return 1'b0;
    return m_busy[a];
  endfunction

  // One clock cycle: drive inputs, record the expected read-side response, then
  // advance the model across the edge.
  task automatic step(input logic r, input logic w, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic bs, input logic [AW-1:0] ba,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    exp_t e;
    rst = r; we = w; rd_addr = wa; rd_data = wd;
    busy_set = bs; busy_addr = ba; rs1_addr = a1; rs2_addr = a2;
    if (!r) begin
      e.d1 = m_read(a1, w, wa, wd);
      e.d2 = m_read(a2, w, wa, wd);
      e.b1 = m_bsy(a1, w, wa);
      e.b2 = m_bsy(a2, w, wa);
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (w && wa != 0) begin
        m_regs[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (bs && ba != 0) m_busy[ba] = 1'b1;
    end
    cyc++;
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req, input int c);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req);
    end
  endtask

  // Monitor: outputs are valid every non-reset cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs1_data", rs1_data, e.d1, e.cyc);
      chk("rs2_data", rs2_data, e.d2, e.cyc);
      chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, e.b1}, e.cyc);
      chk("rs2_busy", {31'b0, rs2_busy}, {31'b0, e.b2}, e.cyc);
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; rd_addr = '0; rd_data = '0;
    busy_set = 1'b0; busy_addr = '0; rs1_addr = '0; rs2_addr = '0;
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset clears a written, busy register
    step(0, 1, 5, 32'hDEADBEEF, 1, 5, 5, 5);
    step(0, 0, 0, 0, 0, 0, 5, 5);
    step(1, 0, 0, 0, 0, 0, 5, 5);
    step(0, 0, 0, 0, 0, 0, 5, 5);

    // x0 protection
    step(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Write, bypass, array read, untouched neighbour
    step(0, 1, 7, 32'h12345678, 0, 0, 8, 7);
    step(0, 0, 0, 0, 0, 0, 8, 7);

    // Scoreboard lifecycle on x10
    step(0, 0, 0, 0, 1, 10, 10, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 10, 10);
    step(0, 1, 10, 32'hA5A5A5A5, 0, 0, 10, 10);
    step(0, 0, 0, 0, 0, 0, 10, 10);
    step(0, 0, 0, 0, 0, 0, 10, 10);

    // Set/clear collision on x3
    step(0, 0, 0, 0, 1, 3, 3, 3);
    step(0, 1, 3, 32'h11, 1, 3, 3, 3);
    step(0, 0, 0, 0, 0, 0, 3, 3);

    // Dual-port same address
    step(0, 1, 15, 32'hCAFEF00D, 0, 0, 15, 15);
    step(0, 0, 0, 0, 0, 0, 15, 15);

    // Random traffic, biased toward a small address window for collisions
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] wa, ba, a1, a2;
      logic w, bs, r;
      int narrow;
      narrow = ($urandom_range(0, 3) != 0) ? 1 : 0;
      wa = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
      ba = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
      a1 = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : (narrow ? AW'($urandom_range(0, 5)) : AW'($urandom));
      w  = ($urandom_range(0, 1) == 1);
      bs = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 99) == 0);
      step(r, w, wa, $urandom, bs, ba, a1, a2);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);

    begin
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      if (q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain pending=%0d required=0", q.size());
      end
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file for the pipelined RISC-V core: one write port (the write-back demultiplexer into the register array) and two combinational read ports feeding the decode stage. It also keeps a per-register pending (busy) scoreboard so the hazard logic can stall on in-flight loads. Register 0 is hardwired to zero and is never written or marked busy.

## Interface
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, register address width; the array holds 2**ADDR_WIDTH registers

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rs1_addr  input  ADDR_WIDTH  read port 1 address
- rs2_addr  input  ADDR_WIDTH  read port 2 address
- rs1_data  output  DATA_WIDTH  read port 1 data (combinational)
- rs2_data  output  DATA_WIDTH  read port 2 data (combinational)
- we  input  1  write enable from write-back stage
- rd_addr  input  ADDR_WIDTH  write address
- rd_data  input  DATA_WIDTH  write data
- busy_set  input  1  mark busy_addr as pending (load issued)
- busy_addr  input  ADDR_WIDTH  register to mark pending
- rs1_busy  output  1  rs1_addr has a pending write not yet resolved
- rs2_busy  output  1  rs2_addr has a pending write not yet resolved

Decided: one clock; reset is synchronous and active-high (clk, rst).

## Operation
- State: register array regs[1 .. 2**ADDR_WIDTH-1] (DATA_WIDTH each) and busy vector busy[1 .. 2**ADDR_WIDTH-1]. No storage for index 0.
- Write: at rising edge, if we and rd_addr != 0, regs[rd_addr] <= rd_data. Writes to address 0 are discarded.
- Read, per port X in {1,2}:
  - rsX_addr == 0 → rsX_data = 0.
  - else if we and rd_addr == rsX_addr → rsX_data = rd_data (same-cycle write-through bypass).
  - else rsX_data = regs[rsX_addr].
- Busy update at rising edge, per register r != 0, in priority order:
  - busy_set and busy_addr == r → busy[r] <= 1 (set wins over a simultaneous clear to the same register).
  - else if we and rd_addr == r → busy[r] <= 0.
  - else hold.
  - busy_set with busy_addr == 0 is ignored.
- Busy outputs, per port X:
  - rsX_busy = 0 when rsX_addr == 0.
  - rsX_busy = 0 when we and rd_addr == rsX_addr, because the bypassed data is valid this cycle.
  - otherwise rsX_busy = busy[rsX_addr].
- Both read ports may address the same register. Both then return identical data and busy values.
- Writing a register that is not busy is legal. The data is updated and busy is unaffected.

## Timing
- Reset: at a rising edge with rst = 1, every regs entry <= 0 and every busy bit <= 0. With rst high, we and busy_set are ignored.
- After reset, with we = 0: rs1_data = rs2_data = 0 and rs1_busy = rs2_busy = 0 for any address.
- A reset asserted while a register is busy clears it; the in-flight write is not re-tracked.
- Read latency is zero cycles; the read path is purely combinational from the address and write-port inputs.
- Write latency is one edge. The value is visible through the array from the cycle after the edge, and through the bypass in the write cycle itself.
- busy_set takes effect at the edge. The register reads busy from the next cycle until the cycle in which its write-back occurs; rsX_busy drops in that write-back cycle via the bypass term.
- Address arithmetic is unsigned. All 2**ADDR_WIDTH addresses are valid, with no wrap or out-of-range case.

## Test plan
- Reset: preload x5 = 0xDEADBEEF and set busy[5], then assert rst for one edge → rs1_addr = 5 reads 0x00000000, rs1_busy = 0.
- x0 protection: we = 1, rd_addr = 0, rd_data = 0xFFFFFFFF, busy_set = 1, busy_addr = 0 → rs1_data = 0 and rs1_busy = 0, both in the same cycle and the next.
- Write/read and bypass: write x7 = 0x12345678.
  - In the write cycle, rs2_addr = 7 → rs2_data = 0x12345678 (bypass).
  - The next cycle, with we = 0 → still 0x12345678.
  - Port 1 reading x8 in that same cycle → 0.
- Scoreboard lifecycle: busy_set on x10 at edge N → rs1_busy = 1 in cycles N+1..N+3. Write x10 = 0xA5A5A5A5 in cycle N+4 → rs1_busy = 0 and rs1_data = 0xA5A5A5A5 in cycle N+4; busy stays clear afterwards.
- Set/clear collision: x3 busy, then in one cycle we = 1, rd_addr = 3, rd_data = 0x11, busy_set = 1, busy_addr = 3 → next cycle rs1_busy = 1 with rs1_data = 0x11.
- Dual-port same address: rs1_addr = rs2_addr = 15 after writing 0xCAFEF00D → both ports read 0xCAFEF00D and both busy outputs are 0.
